// File: rtl/alu_seq.sv
// alu_seq -- registered, handshaked signed ALU with an iterative divider.
//
// Accepts one operation per in_valid/in_ready handshake. Single-cycle ops are
// computed straight from the inputs and registered on the accept edge.
// Div/mod go through an N-step restoring divider that works on operand
// magnitudes, with signs fixed up afterwards. The result and the NZVC flags
// are held until the consumer takes them with out_ready.
//
// Parameters:
//   N          operand/result width (N >= 4)
//   DIV_CYCLES divider iteration count, must equal N
//
// Ports:
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   in_valid, in_ready  request handshake; in_ready is high only in IDLE
//   a, b, ctrl          signed operands and 4-bit opcode
//   out_valid, out_ready result handshake; out_valid is high only in DONE
//   result, flags       registered result and {N, Z, V, C}
//   busy                high whenever the block is not IDLE
//
// Build option:
//   ALU_SEQ_ASR_EN      when defined, opcode 1010 is arithmetic shift right;
//                       otherwise 1010 is an unused opcode.

module alu_seq #(
  parameter int N          = 8,
  parameter int DIV_CYCLES = N
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [3:0]   ctrl,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] result,
  output logic [3:0]   flags,
  output logic         busy
);

  typedef enum logic [1:0] {IDLE, DIV, DONE} state_t;

  localparam int CW = $clog2(DIV_CYCLES);
  localparam logic [CW-1:0] LAST_COUNT = CW'(DIV_CYCLES - 1);
  localparam logic [N-1:0]  SHAMT_MAX  = N'(N);
  localparam logic [N-1:0]  MOST_NEG   = {1'b1, {(N-1){1'b0}}};
  localparam logic [N:0]    ONE_EXT    = {{N{1'b0}}, 1'b1};

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_MUL  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_MOD  = 4'b0100;
  localparam logic [3:0] OP_AND  = 4'b0101;
  localparam logic [3:0] OP_COPY = 4'b0110;
  localparam logic [3:0] OP_SHL  = 4'b0111;
  localparam logic [3:0] OP_DIV  = 4'b1000;
  localparam logic [3:0] OP_SHR  = 4'b1001;
`ifdef ALU_SEQ_ASR_EN
  localparam logic [3:0] OP_ASR  = 4'b1010;
`endif

  state_t          state_q, state_d;
  logic [N-1:0]    result_q, result_d;
  logic [3:0]      flags_q, flags_d;
  logic [CW-1:0]   count_q, count_d;
  logic [N-1:0]    rem_q, rem_d;
  logic [N-1:0]    quo_q, quo_d;
  logic [N-1:0]    dvs_q, dvs_d;
  logic [N-1:0]    a_q, a_d;
  logic [N-1:0]    b_q, b_d;
  logic            is_mod_q, is_mod_d;

  logic [N:0]      sum, diff, shl_ext, shr_ext;
  logic [2*N-1:0]  prod;
  logic            big_shift;
  logic [N-1:0]    alu_res;
  logic            alu_v, alu_c;
  logic [3:0]      alu_flags;
`ifdef ALU_SEQ_ASR_EN
  logic [N:0]      asr_ext;
`endif

  logic [N:0]      rem_shift, trial;
  logic [N-1:0]    step_rem, step_quo;
  logic [N-1:0]    quo_signed, rem_signed;
  logic [N-1:0]    div_res;
  logic            div_v, div_c;
  logic [3:0]      div_flags;

  // Single-cycle datapath. Shifts use a one-bit extension so the last bit
  // shifted out lands in the extra position and becomes the carry; with a
  // zero amount that position holds the padding zero, so C=0 falls out.
  always_comb begin
    sum       = {1'b0, a} + {1'b0, b};
    diff      = {1'b0, a} + {1'b0, ~b} + ONE_EXT;
    prod      = {{N{a[N-1]}}, a} * {{N{b[N-1]}}, b};
    shl_ext   = {1'b0, a} << b;
    shr_ext   = {a, 1'b0} >> b;
    big_shift = (b >= SHAMT_MAX);
`ifdef ALU_SEQ_ASR_EN
    asr_ext   = $signed({a, 1'b0}) >>> b;
`endif
    alu_res   = '0;
    alu_v     = 1'b0;
    alu_c     = 1'b0;
    case (ctrl)
      OP_ADD: begin
        alu_res = sum[N-1:0];
        alu_c   = sum[N];
        alu_v   = (a[N-1] == b[N-1]) && (sum[N-1] != a[N-1]);
      end
      OP_SUB: begin
        alu_res = diff[N-1:0];
        alu_c   = diff[N];
        alu_v   = (a[N-1] != b[N-1]) && (diff[N-1] != a[N-1]);
      end
      OP_MUL: begin
        alu_res = prod[N-1:0];
        // The product fits only if the top N+1 bits are all sign copies.
        alu_v   = (prod[2*N-1:N-1] != '0) && (prod[2*N-1:N-1] != '1);
        alu_c   = alu_v;
      end
      OP_OR:   alu_res = a | b;
      OP_AND:  alu_res = a & b;
      OP_COPY: alu_res = b;
      OP_SHL: begin
        if (!big_shift) begin
          alu_res = shl_ext[N-1:0];
          alu_c   = shl_ext[N];
        end
      end
      OP_SHR: begin
        if (!big_shift) begin
          alu_res = shr_ext[N:1];
          alu_c   = shr_ext[0];
        end
      end
`ifdef ALU_SEQ_ASR_EN
      OP_ASR: begin
        // Past the width every bit shifted out is a sign copy.
        if (big_shift) begin
          alu_res = {N{a[N-1]}};
          alu_c   = a[N-1];
        end else begin
          alu_res = asr_ext[N:1];
          alu_c   = asr_ext[0];
        end
      end
`endif
      default: alu_res = '0;
    endcase
    alu_flags = {alu_res[N-1], (alu_res == '0), alu_v, alu_c};
  end

  // One restoring-divider step plus the final sign fix-up. The fix-up is
  // applied to this step's outputs so the last iteration and the correction
  // share one edge. The partial remainder is always below the divisor
  // magnitude, so the shifted value never needs more than N+1 bits.
  always_comb begin
    rem_shift = {rem_q, quo_q[N-1]};
    trial     = rem_shift - {1'b0, dvs_q};
    if (!trial[N]) begin
      step_rem = trial[N-1:0];
      step_quo = {quo_q[N-2:0], 1'b1};
    end else begin
      step_rem = rem_shift[N-1:0];
      step_quo = {quo_q[N-2:0], 1'b0};
    end
    quo_signed = (a_q[N-1] ^ b_q[N-1]) ? -step_quo : step_quo;
    rem_signed = a_q[N-1] ? -step_rem : step_rem;
    div_v      = 1'b0;
    div_c      = 1'b0;
    if (b_q == '0) begin
      div_res = is_mod_q ? a_q : '1;
      div_v   = 1'b1;
      div_c   = 1'b1;
    end else if ((a_q == MOST_NEG) && (b_q == '1)) begin
      div_res = is_mod_q ? '0 : MOST_NEG;
      div_v   = 1'b1;
    end else begin
      div_res = is_mod_q ? rem_signed : quo_signed;
    end
    div_flags = {div_res[N-1], (div_res == '0), div_v, div_c};
  end

  // Control FSM and datapath register updates.
  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    flags_d  = flags_q;
    count_d  = count_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvs_d    = dvs_q;
    a_d      = a_q;
    b_d      = b_q;
    is_mod_d = is_mod_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          if ((ctrl == OP_DIV) || (ctrl == OP_MOD)) begin
            state_d  = DIV;
            a_d      = a;
            b_d      = b;
            is_mod_d = (ctrl == OP_MOD);
            quo_d    = a[N-1] ? -a : a;
            dvs_d    = b[N-1] ? -b : b;
            rem_d    = '0;
            count_d  = '0;
          end else begin
            result_d = alu_res;
            flags_d  = alu_flags;
            state_d  = DONE;
          end
        end
      end
      DIV: begin
        rem_d   = step_rem;
        quo_d   = step_quo;
        count_d = count_q + CW'(1);
        if (count_q == LAST_COUNT) begin
          result_d = div_res;
          flags_d  = div_flags;
          state_d  = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      result_q <= '0;
      flags_q  <= '0;
      count_q  <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      is_mod_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      flags_q  <= flags_d;
      count_q  <= count_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvs_q    <= dvs_d;
      a_q      <= a_d;
      b_q      <= b_d;
      is_mod_q <= is_mod_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign result    = result_q;
  assign flags     = flags_q;

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, registered successor to the single-cycle combinational ALU in the TessiaV1 datapath.
- Accepts one signed operation per valid/ready handshake.
- Executes the single-cycle ops in 1 cycle, and divide/modulus with an iterative N-step restoring divider.
- Holds result and NZVC flags in output registers until the consumer accepts them; sits between register-file read and writeback.

Parameters:
N, 8, operand/result width in bits (N >= 4)
DIV_CYCLES, N, iterations of the divider (must equal N; exposed for bench visibility only)

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  asynchronous active-high reset
in_valid  input  1  operation request valid
in_ready  output  1  block can accept an operation
a  input  N  signed operand A
b  input  N  signed operand B / immediate / shift amount
ctrl  input  4  opcode (see Behaviour)
out_valid  output  1  result and flags valid
out_ready  input  1  consumer accepts result
result  output  N  signed result
flags  output  4  [3]=N negative, [2]=Z zero, [1]=V overflow, [0]=C carry
busy  output  1  high whenever state != IDLE

Behaviour:
- Opcodes:
  - 0000 add; 0001 sub; 0010 mul (low N bits); 0011 or
  - 0100 signed mod; 0101 and; 0110 copy b; 0111 shl
  - 1000 signed div; 1001 logical shr
  - others: result 0, flags 0000 except Z=1
- Reset, asynchronous and immediate: state=IDLE; result=0; flags=0000; out_valid=0; busy=0; in_ready=1. Reset mid-division aborts the operation with no output.
- States:
  - IDLE: in_ready=1. On in_valid, latch a/b/ctrl. ctrl in {0100,1000} -> DIV; else compute and register the result, then -> DONE.
  - DIV: counter runs 0..N-1, one quotient bit per cycle on the operand magnitudes. After the N-th iteration, sign correction is applied -> DONE.
  - DONE: out_valid=1; result/flags stable. out_ready=1 -> IDLE (out_valid drops next cycle).
- Latency (accept edge to out_valid high): 1 cycle for single-cycle ops, N+1 cycles for div/mod. in_ready=0 outside IDLE, so there is no back-to-back overlap; throughput is one op per 2 cycles minimum.
- Inputs a/b/ctrl are don't-care after the accept edge.
- Arithmetic and flags:
  - add: C = unsigned carry out of bit N-1; V = signed overflow (operands have equal signs, result sign differs).
  - sub: computed as a + ~b + 1; C = 1 when no borrow (a >= b unsigned); V = signed overflow (operand signs differ, result sign != a sign).
  - mul: full 2N-bit signed product; result = low N bits; V=C=1 when the product does not sign-fit in N bits.
  - div: quotient truncates toward zero.
  - mod: remainder takes the sign of a.
  - Most-negative / -1: quotient = most-negative, remainder = 0, V=1.
  - Divide by zero: quotient = all ones, remainder = a, V=1, C=1.
  - shl/shr: shift amount = b interpreted unsigned; amount >= N gives 0; C = last bit shifted out (0 when amount is 0 or >= N); V=0.
  - Logic/copy ops: V=C=0.
  - All ops: N = result[N-1]; Z = (result == 0). V and N are independent; N is not suppressed on overflow.
- Simultaneous events: in_valid while not in IDLE is ignored (not accepted). out_ready outside DONE is ignored.

Optional Feature:
- Macro: ALU_SEQ_ASR_EN
- Defined: opcode 1010 = arithmetic shift right, sign-filling. Amount >= N gives all sign bits. C = last bit out; V=0. Single-cycle latency.
- Undefined: 1010 behaves as an unused opcode (result 0, Z=1).

Test Plan:
- Reset with in_valid=1 asserted -> in_ready=1, out_valid=0, result=0, flags=0000. Release reset; next edge accepts the op.
- N=8 add a=0x7F, b=0x01 -> 1 cycle later result=0x80, flags=1010 (N=1,V=1); hold out_ready=0 for 3 cycles -> outputs stable, in_ready=0.
- Sub a=0x05, b=0x05 -> result=0x00, flags=0101 (Z, C). Mul a=0x10, b=0x10 -> result=0x00, flags=0111.
- Div a=-7 (0xF9), b=2 -> out_valid exactly 9 cycles after accept, result=0xFD (-3). Mod same operands -> result=0xFF (-1), flags=1000.
- Div a=0x23, b=0 -> result=0xFF, flags=1011. Div 0x80 / 0xFF -> result=0x80, V=1. Assert rst on DIV cycle 4 -> immediate IDLE, no out_valid.
- Shl a=0x81, b=1 -> 0x02, C=1; shr b=9 -> 0x00, Z=1, C=0. With ALU_SEQ_ASR_EN: 1010, a=0x80, b=3 -> 0xF0, N=1.
